// File: rtl/req_output_arbiter_if.sv
// Request-port bundle between NUM_SRC network FIFO outputs, the arbiter and the nodeset port.
// master: arbiter side (samples source words and downstream ack, drives reads and output word).
// slave : environment side (FIFOs present words, downstream consumes the registered word).
// Ports: i_req_vld/i_req_payload/i_req_nodenum per source, o_req_ack one-hot read enable,
//        o_req_vld/o_req_payload/o_req_nodenum/o_req_src output word, i_req_ack downstream consume.
interface req_output_arbiter_if #(
  parameter int NUM_SRC       = 2,
  parameter int PAYLOAD_WIDTH = 16,
  parameter int NODETAG_WIDTH = 6
);
  localparam int SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0]                    i_req_vld;
  logic [NUM_SRC-1:0][PAYLOAD_WIDTH-1:0] i_req_payload;
  logic [NUM_SRC-1:0][NODETAG_WIDTH-1:0] i_req_nodenum;
  logic [NUM_SRC-1:0]                    o_req_ack;
  logic                                  o_req_vld;
  logic [PAYLOAD_WIDTH-1:0]              o_req_payload;
  logic [NODETAG_WIDTH-1:0]              o_req_nodenum;
  logic [SRC_W-1:0]                      o_req_src;
  logic                                  i_req_ack;

  modport master (
    input  i_req_vld, i_req_payload, i_req_nodenum, i_req_ack,
    output o_req_ack, o_req_vld, o_req_payload, o_req_nodenum, o_req_src
  );

  modport slave (
    output i_req_vld, i_req_payload, i_req_nodenum, i_req_ack,
    input  o_req_ack, o_req_vld, o_req_payload, o_req_nodenum, o_req_src
  );
endinterface

// File: rtl/req_output_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one nodeset request port among NUM_SRC FIFOs.
// Latency: 1 cycle from grant (o_req_ack) to o_req_vld; 1 word/cycle under continuous i_req_ack.
// Backpressure: while o_req_vld=1 and i_req_ack=0 no grant is issued and all state holds.
// Ports: clk, rst (async active-low), bus (req_output_arbiter_if.master):
//   i_req_vld/payload/nodenum per source in, o_req_ack one-hot read enable out,
//   o_req_vld/payload/nodenum/src registered word out, i_req_ack downstream consume in.
module req_output_arbiter #(
  parameter int NUM_SRC       = 2,
  parameter int PAYLOAD_WIDTH = 16,
  parameter int NODETAG_WIDTH = 6,
  parameter int MAX_BURST     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  req_output_arbiter_if.master   bus
);
  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t           state;
  logic [SRC_W-1:0] rr_ptr;
  logic [SRC_W-1:0] owner;
  logic [CNT_W-1:0] burst_cnt;

  logic             load_en;
  logic             owner_vld;
  logic [SRC_W-1:0] owner_next;
  logic [SRC_W-1:0] search_base;
  logic [SRC_W-1:0] cand;
  logic             rr_found;
  logic [SRC_W-1:0] rr_idx;
  logic             grant_vld;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] grant_next;
  logic             burst_cont;

  // Index arithmetic modulo NUM_SRC; works for non-power-of-2 source counts.
  function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_SRC) s = s - NUM_SRC;
    return SRC_W'(s);
  endfunction

  always_comb begin
    load_en    = !bus.o_req_vld || bus.i_req_ack;
    owner_vld  = bus.i_req_vld[owner];
    owner_next = wrap_add(owner, 1);

    // When the owner runs dry mid-burst, the search restarts just past it in the
    // same cycle so another valid source is granted without a bubble.
    search_base = (state == S_BURST) ? owner_next : rr_ptr;

    rr_found = 1'b0;
    rr_idx   = '0;
    cand     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      cand = wrap_add(search_base, i);
      if (!rr_found && bus.i_req_vld[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end

    burst_cont = (state == S_BURST) && owner_vld;

    grant_vld = 1'b0;
    grant_idx = rr_idx;
    // Gated by rst so no FIFO is popped while the arbiter is held in reset.
    if (rst && load_en) begin
      if (burst_cont) begin
        grant_vld = 1'b1;
        grant_idx = owner;
      end else if (rr_found) begin
        grant_vld = 1'b1;
        grant_idx = rr_idx;
      end
    end
    grant_next = wrap_add(grant_idx, 1);

    bus.o_req_ack = '0;
    if (grant_vld) bus.o_req_ack = NUM_SRC'(1) << grant_idx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= S_IDLE;
      rr_ptr            <= '0;
      owner             <= '0;
      burst_cnt         <= '0;
      bus.o_req_vld     <= 1'b0;
      bus.o_req_payload <= '0;
      bus.o_req_nodenum <= '0;
      bus.o_req_src     <= '0;
    end else if (load_en) begin
      // Output register drains when nothing is granted.
      bus.o_req_vld <= grant_vld;
      if (grant_vld) begin
        bus.o_req_payload <= bus.i_req_payload[grant_idx];
        bus.o_req_nodenum <= bus.i_req_nodenum[grant_idx];
        bus.o_req_src     <= grant_idx;
      end

      if (burst_cont) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
        if (burst_cnt == CNT_W'(MAX_BURST - 1)) begin
          // Burst exhausted: the owner drops to lowest priority.
          rr_ptr <= owner_next;
          state  <= S_IDLE;
        end
      end else if (grant_vld) begin
        // New owner, either from IDLE or after the previous owner ran dry.
        owner     <= grant_idx;
        burst_cnt <= CNT_W'(1);
        if (state == S_BURST) rr_ptr <= owner_next;
        if (MAX_BURST == 1) begin
          rr_ptr <= grant_next;
          state  <= S_IDLE;
        end else begin
          state <= S_BURST;
        end
      end else if (state == S_BURST) begin
        // Owner went empty and no other source is waiting.
        rr_ptr <= owner_next;
        state  <= S_IDLE;
      end
    end
  end
endmodule
